// File: rtl/inst_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: inst_mgmt select codes,
// FSM state encoding, PC step and word-alignment helper.
package inst_ctrl_pkg;

  // Select codes understood by inst_mgmt.
  localparam logic [1:0] INST_MEM = 2'b00;  // take the word on imem rdata
  localparam logic [1:0] INST_OLD = 2'b01;  // re-present the held instruction
  localparam logic [1:0] INST_NOP = 2'b10;  // inject a bubble

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam logic [31:0] PC_INC = 32'd4;

  // Redirect targets are word addresses; drop any stray byte offset.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_ctrl.sv
// Fetch sequencer: drives the instruction-memory address and the inst_mgmt
// select, arbitrating redirect > load-use stall > memory not-ready > advance.
// pc_q is always the PC of the word arriving on rdata this cycle.
module inst_ctrl
  import inst_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FLUSH_NOPS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        stall_req,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  output logic [1:0]  inst_sel,
  output logic [31:0] inst_pc
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_NOPS);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0] pc_next_seq;
  logic [31:0] jump_target;

  assign pc_next_seq = pc_q + PC_INC;
  assign jump_target = align_word(jump_addr);
  assign inst_pc     = pc_q;

  // Next-state, fetch address and select decode.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch,
    // so no path can leave a value unassigned and infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    flush_cnt_d = flush_cnt_q;
    inst_sel    = INST_NOP;
    imem_addr   = pc_q;

    if (rst) begin
      imem_addr = RESET_PC;
    end else if (state_q == ST_BOOT) begin
      // First fetch after reset; the word returns next cycle with pc_q=RESET_PC.
      imem_addr = RESET_PC;
      pc_d      = RESET_PC;
      state_d   = ST_RUN;
    end else if (jump_en) begin
      // Squash the wrong-path word and start fetching at the target.
      imem_addr   = jump_target;
      pc_d        = jump_target;
      flush_cnt_d = FLUSH_INIT;
      state_d     = (FLUSH_NOPS > 0) ? ST_FLUSH : ST_RUN;
    end else if (state_q == ST_FLUSH) begin
      // Keep re-issuing the target while the extra bubbles drain.
      flush_cnt_d = flush_cnt_q - 3'd1;
      if (flush_cnt_q <= 3'd1) begin
        state_d = ST_RUN;
      end
    end else if (stall_req) begin
      // Refetch pc_q so the held word is still on rdata when the stall lifts.
      inst_sel = INST_OLD;
      state_d  = ST_STALL;
    end else if (!imem_ready) begin
      state_d = ST_RUN;
    end else begin
      inst_sel  = INST_MEM;
      imem_addr = pc_next_seq;
      pc_d      = pc_next_seq;
      state_d   = ST_RUN;
    end
  end

  // State, PC and flush counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
